// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Definitions shared by the whack-a-mole game controller and the player-side
// button front end.
//   NUM_BUTTONS / BTN_IDX_W : button count and width of an encoded index
//   BTN0..BTN3              : button index codes (button1 = BTN0 .. button4 = BTN3)
//   HIT / MISS              : result codes used by the game controller
//   btn_evt_t               : one queued press event {idx, multi}
//   encode_press()          : turns a one-cycle press vector into an event
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int NUM_BUTTONS = 4;
   localparam int BTN_IDX_W   = 2;

   localparam logic [BTN_IDX_W-1:0] BTN0 = 2'd0;
   localparam logic [BTN_IDX_W-1:0] BTN1 = 2'd1;
   localparam logic [BTN_IDX_W-1:0] BTN2 = 2'd2;
   localparam logic [BTN_IDX_W-1:0] BTN3 = 2'd3;

   localparam logic [1:0] HIT  = 2'b11;
   localparam logic [1:0] MISS = 2'b01;

   typedef struct packed {
      logic [BTN_IDX_W-1:0] idx;
      logic                 multi;
   } btn_evt_t;

   // Lowest pressed button wins the index; multi flags simultaneous presses
   // so the controller knows the index alone does not tell the whole story.
   function automatic btn_evt_t encode_press(input logic [NUM_BUTTONS-1:0] press);
      btn_evt_t evt;
      evt.idx   = BTN0;
      evt.multi = ($countones(press) > 1);
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         if (press[i]) begin
            evt.idx = BTN_IDX_W'(i);
         end
      end
      return evt;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// One button: two-flop synchroniser, stability counter and accepted level,
// plus a one-cycle press pulse on each accepted low-to-high change.
// Ports:
//   clk     : system clock, rising edge
//   rst     : asynchronous reset, active low
//   btn_raw : raw button, active high, asynchronous to clk
//   level   : debounced level
//   press   : one-cycle pulse, the cycle after level rises
// -----------------------------------------------------------------------------
module debounce_cell #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             stable_q, stable_d;
   logic             stable_prev_q, stable_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d          = btn_raw;
      s2_d          = s1_q;
      stable_prev_d = stable_q;
      stable_d      = stable_q;
      cnt_d         = '0;
      // The counter only runs while the synchronised input disagrees with
      // the accepted level; any agreement restarts the count.
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_MAX) begin
            stable_d = s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q          <= 1'b0;
         s2_q          <= 1'b0;
         stable_q      <= 1'b0;
         stable_prev_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         cnt_q         <= cnt_d;
      end
   end

   assign level = stable_q;
   assign press = stable_q & ~stable_prev_q;

endmodule

// File: rtl/button_event_encoder.sv
// -----------------------------------------------------------------------------
// button_event_encoder
// Player-side input front end: debounces four raw buttons, turns each press
// into an encoded index and queues it in a first-word-fallthrough FIFO that
// the game controller drains over a valid/ready handshake.
// Ports:
//   clk, rst            : clock (rising edge), async active-low reset
//   button1..button4    : raw buttons, active high, asynchronous
//   evt_ready           : consumer accepts the head event this cycle
//   clear_overflow      : clears the sticky overflow flag on the next edge
//   evt_valid           : queue non-empty, head event presented
//   evt_idx, evt_multi  : head event index and simultaneous-press flag
//   any_down            : registered OR of the debounced levels
//   overflow            : sticky, a press was dropped on a full queue
// -----------------------------------------------------------------------------
module button_event_encoder
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 button1,
   input  logic                 button2,
   input  logic                 button3,
   input  logic                 button4,
   input  logic                 evt_ready,
   input  logic                 clear_overflow,
   output logic                 evt_valid,
   output logic [BTN_IDX_W-1:0] evt_idx,
   output logic                 evt_multi,
   output logic                 any_down,
   output logic                 overflow
);

   localparam int               PTR_W    = $clog2(FIFO_DEPTH);
   localparam int               CNT_W    = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [NUM_BUTTONS-1:0] btn_raw;
   logic [NUM_BUTTONS-1:0] level;
   logic [NUM_BUTTONS-1:0] press;

   assign btn_raw = {button4, button3, button2, button1};

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
      debounce_cell #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
         .clk    (clk),
         .rst    (rst),
         .btn_raw(btn_raw[i]),
         .level  (level[i]),
         .press  (press[i])
      );
   end

   btn_evt_t         mem_q [FIFO_DEPTH];
   btn_evt_t         new_evt;
   btn_evt_t         head_evt;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             any_down_q, any_down_d;
   logic             press_any;
   logic             pop;
   logic             push;
   logic             drop;

   always_comb begin
      press_any = |press;
      new_evt   = encode_press(press);
      pop       = (count_q != '0) && evt_ready;
      // A pop in the same cycle frees the slot, so a full queue still
      // accepts the new event and the count stays put.
      push      = press_any && ((count_q != FULL_CNT) || pop);
      drop      = press_any && !push;

      wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d   = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // A fresh drop outranks a clear requested in the same cycle.
      overflow_d = drop | (overflow_q & ~clear_overflow);
      any_down_d = |level;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         any_down_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         any_down_q <= any_down_d;
      end
   end

   // Event storage carries no reset; an empty queue masks it at the outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= new_evt;
      end
   end

   assign head_evt  = mem_q[rd_ptr_q];
   assign evt_valid = (count_q != '0);
   assign evt_idx   = evt_valid ? head_evt.idx   : '0;
   assign evt_multi = evt_valid ? head_evt.multi : 1'b0;
   assign any_down  = any_down_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_encoder
// Directed scenarios followed by random button/handshake traffic, all compared
// every cycle against a queue-based reference model of the event front end.
// -----------------------------------------------------------------------------
module tb_button_event_encoder;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btn = 4'b0000;
   logic       evt_ready = 1'b0;
   logic       clear_overflow = 1'b0;
   logic       button1, button2, button3, button4;
   logic       evt_valid;
   logic [1:0] evt_idx;
   logic       evt_multi;
   logic       any_down;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   assign button1 = btn[0];
   assign button2 = btn[1];
   assign button3 = btn[2];
   assign button4 = btn[3];

   always #5 clk = ~clk;

   button_event_encoder #(
      .DEBOUNCE_CYCLES(DEB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .button1       (button1),
      .button2       (button2),
      .button3       (button3),
      .button4       (button4),
      .evt_ready     (evt_ready),
      .clear_overflow(clear_overflow),
      .evt_valid     (evt_valid),
      .evt_idx       (evt_idx),
      .evt_multi     (evt_multi),
      .any_down      (any_down),
      .overflow      (overflow)
   );

   // Reference model. Raw samples are kept per edge; the synchroniser is a
   // two-sample delay, and a level is accepted once the last DEB delayed
   // samples all disagree with it. Events live in a queue as idx + 4*multi.
   logic [3:0] m_hist[$];
   logic [3:0] m_stable;
   logic [3:0] m_press;
   int         m_fifo[$];
   bit         m_ovf;
   bit         m_any;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      for (int i = 0; i < DEB + 2; i++) m_hist.push_back(4'b0000);
      m_stable = 4'b0000;
      m_press  = 4'b0000;
      m_fifo.delete();
      m_ovf    = 1'b0;
      m_any    = 1'b0;
   endtask

   task automatic model_edge();
      int         pre;
      int         lowest;
      bit         pop;
      bit         drop;
      bit         all_differ;
      logic [3:0] ns;
      pre  = m_fifo.size();
      pop  = (pre != 0) && evt_ready;
      drop = 1'b0;
      if (pop) void'(m_fifo.pop_front());
      if (m_press != 4'b0000) begin
         lowest = 0;
         for (int i = 3; i >= 0; i--) if (m_press[i]) lowest = i;
         if (pre < DEPTH || pop)
            m_fifo.push_back(lowest + (($countones(m_press) > 1) ? 4 : 0));
         else
            drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clear_overflow) m_ovf = 1'b0;
      m_any = |m_stable;
      m_hist.push_back(btn);
      if (m_hist.size() > DEB + 2) void'(m_hist.pop_front());
      for (int i = 0; i < 4; i++) begin
         all_differ = 1'b1;
         for (int j = 0; j < DEB; j++)
            if (m_hist[m_hist.size() - 3 - j][i] == m_stable[i]) all_differ = 1'b0;
         ns[i] = all_differ ? ~m_stable[i] : m_stable[i];
      end
      m_press  = ns & ~m_stable;
      m_stable = ns;
   endtask

   task automatic compare_all();
      bit has;
      has = (m_fifo.size() != 0);
      check("evt_valid", evt_valid, has);
      check("evt_idx", evt_idx, has ? m_fifo[0] % 4 : 0);
      check("evt_multi", evt_multi, has ? m_fifo[0] / 4 : 0);
      check("any_down", any_down, m_any);
      check("overflow", overflow, m_ovf);
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         if (!rst) model_reset();
         else model_edge();
         #1;
         compare_all();
      end
   endtask

   task automatic assert_reset();
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
   endtask

   task automatic press_release(input logic [3:0] b);
      btn = b;
      tick(8);
      btn = 4'b0000;
      tick(8);
   endtask

   int exp_order[4];

   initial begin
      // Reset held, then idle
      model_reset();
      #1;
      compare_all();
      tick(20);
      rst = 1'b1;
      tick(3);
      check("idle_valid", evt_valid, 0);

      // Single press on button3: latency and handshake
      btn = 4'b0100;
      tick(6);
      check("lat_not_yet", evt_valid, 0);
      tick(1);
      check("lat_valid", evt_valid, 1);
      check("lat_idx", evt_idx, 2);
      check("lat_multi", evt_multi, 0);
      check("lat_any_down", any_down, 1);
      tick(3);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("pop_empty", evt_valid, 0);
      btn = 4'b0000;
      tick(12);
      check("release_no_evt", evt_valid, 0);
      check("release_any_down", any_down, 0);

      // Glitch rejection, then a minimum-length accepted pulse
      btn = 4'b0001;
      tick(3);
      btn = 4'b0000;
      tick(10);
      check("glitch_no_evt", evt_valid, 0);
      btn = 4'b0001;
      tick(4);
      btn = 4'b0000;
      tick(10);
      check("pulse4_valid", evt_valid, 1);
      check("pulse4_idx", evt_idx, 0);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("pulse4_single", evt_valid, 0);

      // Simultaneous presses
      btn = 4'b1010;
      tick(10);
      check("multi_idx", evt_idx, 1);
      check("multi_flag", evt_multi, 1);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      btn = 4'b0000;
      tick(10);
      check("multi_one_evt", evt_valid, 0);

      // Five presses into a four-deep queue
      press_release(4'b0001);
      press_release(4'b0010);
      press_release(4'b0100);
      press_release(4'b1000);
      press_release(4'b0001);
      check("ovf_set", overflow, 1);
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_valid", evt_valid, 1);
         check("drain_idx", evt_idx, i);
         tick(1);
      end
      evt_ready = 1'b0;
      check("drain_empty", evt_valid, 0);
      clear_overflow = 1'b1;
      tick(1);
      clear_overflow = 1'b0;
      check("ovf_clear", overflow, 0);

      // Full queue, press lands on the same edge as a pop
      press_release(4'b0001);
      press_release(4'b0010);
      press_release(4'b0100);
      press_release(4'b1000);
      btn = 4'b0010;
      tick(6);
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
      check("swap_no_ovf", overflow, 0);
      check("swap_head", evt_idx, 1);
      btn = 4'b0000;
      tick(8);
      exp_order = '{1, 2, 3, 1};
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("swap_drain_idx", evt_idx, exp_order[i]);
         tick(1);
      end
      evt_ready = 1'b0;
      check("swap_drain_empty", evt_valid, 0);

      // Reset in the middle of a debounce
      btn = 4'b0010;
      tick(3);
      assert_reset();
      tick(3);
      btn = 4'b0000;
      rst = 1'b1;
      tick(15);
      check("rst_mid_no_evt", evt_valid, 0);
      check("rst_mid_any_down", any_down, 0);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
         evt_ready      = ($urandom_range(0, 3) == 0);
         clear_overflow = ($urandom_range(0, 15) == 0);
         tick(1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/button_event_encoder.md
Name: button_event_encoder

Overview:
- Player-side input front end for the whack-a-mole game. The game controller drives the lights; this block reads the buttons back.
- Synchronises and debounces the four raw buttons and detects press edges. Each press becomes an encoded index, queued in a small FIFO.
- Events go out on a valid/ready handshake, so the game controller receives exactly one event per physical press, in press order.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a level change (10 ms at 50 MHz); must be >= 2.
- FIFO_DEPTH, 4: event queue depth; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- button1  input  1  raw button 0, active-high, asynchronous to clk
- button2  input  1  raw button 1
- button3  input  1  raw button 2
- button4  input  1  raw button 3
- evt_ready  input  1  consumer accepts the head event this cycle
- clear_overflow  input  1  synchronous clear of the overflow flag
- evt_valid  output  1  FIFO non-empty; head event presented
- evt_idx  output  2  head event button index (button1=0 .. button4=3)
- evt_multi  output  1  head event had more than one press edge in the same cycle
- any_down  output  1  OR of the four debounced levels
- overflow  output  1  sticky: a press was dropped because the FIFO was full

Behaviour:
- Reset (rst=0, async):
  - Synchronisers, debounced levels, debounce counters, FIFO pointers and count all clear to 0.
  - Outputs: evt_valid=0, evt_idx=0, evt_multi=0, any_down=0, overflow=0.
  - Reset mid-debounce or with a non-empty FIFO discards everything; nothing is replayed after release.
- Synchronise: each button passes through two flops (s1, s2).
- Debounce (per button):
  - Keep a stable level and a counter.
  - If s2 == stable, counter = 0.
  - Else counter increments. When counter == DEBOUNCE_CYCLES-1 and s2 still differs, stable <= s2 and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Edge detect: press[i] = stable[i] & ~stable_d[i], where stable_d is stable registered one cycle. Releases generate no event.
- Encode:
  - If any press[i] is set, push one entry {idx = lowest set i, multi = (popcount(press) > 1)}.
  - Only one entry per cycle.
- Latency: raw input held high from rising edge 1 gives evt_valid=1 after edge DEBOUNCE_CYCLES+3 (empty FIFO).
- FIFO: first-word-fallthrough.
  - evt_valid = (count != 0). evt_idx and evt_multi come from registered head storage, with no combinational path from buttons.
  - Pop when evt_valid & evt_ready. evt_ready while empty is ignored.
  - Push when a press occurs and (count < FIFO_DEPTH or a pop happens in the same cycle).
  - Full with a simultaneous push and pop: both occur, count unchanged.
  - Full, press, and no pop: the entry is dropped and overflow <= 1.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- overflow:
  - Cleared by clear_overflow=1 on the next edge.
  - If clear_overflow and a new drop occur in the same cycle, overflow stays 1.
- any_down: registered OR of the stable levels; the game controller uses it to wait for release.

Decomposition:
- Shared package game_pkg:
  - NUM_BUTTONS=4 and BTN_IDX_W=2.
  - Button index constants BTN0..BTN3.
  - Result codes HIT=2'b11 and MISS=2'b01, shared with the game controller.
- Natural sub-module: debounce_cell.
  - Contents: 2-flop synchroniser, counter and stable level for one button.
  - Outputs: level, press.
  - Instantiated four times.
  - The FIFO stays inline.

Test Plan (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4):
- Reset then idle: all outputs 0 for 20 cycles; raise rst; still 0.
- button3 high from edge 1, held 10 cycles, evt_ready=0 → evt_valid=1 after edge 7, evt_idx=2, evt_multi=0, any_down=1. One evt_ready pulse → evt_valid=0. Release produces no event.
- button1 glitch high for 3 cycles → no event, any_down stays 0. A 4-cycle pulse followed by low → exactly one event, idx=0.
- button2 and button4 rise on the same edge → one event: idx=1, multi=1.
- Five distinct presses with evt_ready=0 → four queued, in order (0,1,2,3), and overflow=1. Drain with evt_ready=1: four pops, then evt_valid=0. clear_overflow → overflow=0.
- FIFO full, press completes on the same cycle as a pop → count stays 4, no overflow, new idx appears last. Then rst=0 mid-debounce of button2 → all outputs 0 and no event after release.
